// File: rtl/alu64.sv
// -----------------------------------------------------------------------------
// alu64 - registered integer ALU for the LEGv8 datapath.
//
// Computes AND, OR, ADD, SUB or PASS-B on two WIDTH-bit operands and registers
// the result together with a zero flag (consumed by the CBZ/branch logic).
// Latency is exactly one clock and one operation is accepted every cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    a/b/ALUControl are valid this cycle
//   a, b        WIDTH-bit two's complement operands
//   ALUControl  4-bit operation select
//                 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS-B,
//                 any other code produces 0
//   result      registered operation result (modulo 2^WIDTH)
//   zero        registered flag, 1 when result == 0
//   out_valid   result/zero were loaded from an input accepted last cycle
//
// Optional build macro ALU_FLAGS_EN adds registered status outputs with the
// same timing and reset behaviour as zero:
//   negative    result[WIDTH-1]
//   carry       carry-out of ADD, NOT borrow of SUB, 0 otherwise
//   overflow    signed overflow of ADD/SUB, 0 otherwise
// -----------------------------------------------------------------------------
module alu64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic             negative,
    output logic             carry,
    output logic             overflow
`endif
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;

    // A single adder serves both ADD and SUB: a - b = a + ~b + 1.
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;

    assign is_sub = (ALUControl == OP_SUB);
    assign b_eff  = is_sub ? ~b : b;

`ifdef ALU_FLAGS_EN
    // One extra bit captures the carry-out; result itself stays truncated.
    logic [WIDTH:0] sum_wide;
    assign sum_wide = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign sum      = sum_wide[WIDTH-1:0];
`else
    assign sum = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
`endif

    logic [WIDTH-1:0] next_result;
    logic             next_zero;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // next_result unassigned, which would otherwise infer a latch.
        next_result = '0;
        case (ALUControl)
            OP_AND:         next_result = a & b;
            OP_OR:          next_result = a | b;
            OP_ADD, OP_SUB: next_result = sum;
            OP_PASS:        next_result = b;
            default:        next_result = '0;
        endcase
    end

    // Derived from the truncated WIDTH-bit value, never from sum_wide.
    assign next_zero = (next_result == '0);

`ifdef ALU_FLAGS_EN
    logic next_carry;
    logic next_overflow;

    always_comb begin
        next_carry    = 1'b0;
        next_overflow = 1'b0;
        if (ALUControl == OP_ADD || ALUControl == OP_SUB) begin
            next_carry    = sum_wide[WIDTH];
            // Signed overflow: both adder inputs share a sign that the sum lost.
            next_overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                            (sum[WIDTH-1] != a[WIDTH-1]);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            out_valid <= in_valid;
            // Without in_valid the outputs hold, so garbage on a/b is ignored.
            if (in_valid) begin
                result    <= next_result;
                zero      <= next_zero;
`ifdef ALU_FLAGS_EN
                negative  <= next_result[WIDTH-1];
                carry     <= next_carry;
                overflow  <= next_overflow;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu64.sv
// -----------------------------------------------------------------------------
// tb_alu64 - self-checking bench for alu64.
// Each drive() pushes the expected result onto a scoreboard queue; each
// tick_check() waits one rising edge, samples 1 time unit later and pops and
// compares when out_valid is expected, otherwise confirms the outputs held.
// -----------------------------------------------------------------------------
module tb_alu64;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_ctl;
    logic [W-1:0] result;
    logic         zero;
    logic         out_valid;
`ifdef ALU_FLAGS_EN
    logic         negative;
    logic         carry;
    logic         overflow;
`endif

    alu64 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .ALUControl (alu_ctl),
        .result     (result),
        .zero       (zero),
        .out_valid  (out_valid)
`ifdef ALU_FLAGS_EN
        ,
        .negative   (negative),
        .carry      (carry),
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zf;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   errors = 0;
    int   checks = 0;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_PASS = 4'b0111;

    // Present one operation and record what must appear one cycle later.
    task automatic drive(input logic [3:0] op, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic [W-1:0] exp_res);
        exp_t e;
        in_valid = 1'b1;
        alu_ctl  = op;
        a        = va;
        b        = vb;
        e.res    = exp_res;
        e.zf     = (exp_res == '0);
        sb.push_back(e);
    endtask

    // Deassert in_valid with random junk on the data/control inputs.
    task automatic idle();
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        alu_ctl  = 4'($urandom_range(0, 15));
    endtask

    task automatic tick_check(input string name, input logic exp_valid);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== exp_valid) begin
            errors++;
            $display("FAIL %s out_valid: got %0b want %0b", name, out_valid, exp_valid);
        end
        if (exp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s scoreboard empty: got result %h want a queued entry", name, result);
            end else begin
                e    = sb.pop_front();
                last = e;
                checks += 2;
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL %s result: got %h want %h", name, result, e.res);
                end
                if (zero !== e.zf) begin
                    errors++;
                    $display("FAIL %s zero: got %0b want %0b", name, zero, e.zf);
                end
            end
        end else begin
            checks += 2;
            if (result !== last.res) begin
                errors++;
                $display("FAIL %s held result: got %h want %h", name, result, last.res);
            end
            if (zero !== last.zf) begin
                errors++;
                $display("FAIL %s held zero: got %0b want %0b", name, zero, last.zf);
            end
        end
    endtask

    task automatic check_reset_state(input string name);
        checks += 3;
        if (result !== '0) begin
            errors++;
            $display("FAIL %s result: got %h want 0", name, result);
        end
        if (zero !== 1'b1) begin
            errors++;
            $display("FAIL %s zero: got %0b want 1", name, zero);
        end
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s out_valid: got %0b want 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #23;
        check_reset_state("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;
        last.res = '0;
        last.zf  = 1'b1;
        tick_check("reset_release_idle", 1'b0);
        // Load a nonzero value, then reset asynchronously mid-cycle with a
        // new operation in flight; it must be discarded.
        drive(C_PASS, 64'd1, 64'h1234, 64'h1234);
        tick_check("reset_preload", 1'b1);
        drive(C_PASS, 64'd0, 64'h5678, 64'h5678);
        void'(sb.pop_back());
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_async_midcycle");
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        last.res = '0;
        last.zf  = 1'b1;
        tick_check("reset_after_release", 1'b0);
    endtask

    task automatic test_logic();
        drive(C_AND, 64'd1206, 64'd4404, 64'd52);
        tick_check("and_52", 1'b1);
        drive(C_AND, 64'd2060, 64'd4512, 64'd0);
        tick_check("and_zero", 1'b1);
        drive(C_OR, 64'd4249, 64'd3605, 64'd7837);
        tick_check("or_pos", 1'b1);
        drive(C_OR, 64'd4967, -64'sd1791, -64'sd1177);
        tick_check("or_neg", 1'b1);
        idle();
    endtask

    task automatic test_arith();
        drive(C_ADD, 64'd4781, 64'd1346, 64'd6127);
        tick_check("add_pos", 1'b1);
        drive(C_ADD, -64'sd3112, 64'd2260, -64'sd852);
        tick_check("add_neg", 1'b1);
        drive(C_SUB, 64'd2108, 64'd2669, -64'sd561);
        tick_check("sub_neg", 1'b1);
        drive(C_SUB, 64'd2561, -64'sd1864, 64'd4425);
        tick_check("sub_negb", 1'b1);
        drive(C_ADD, 64'd0, 64'd0, 64'd0);
        tick_check("add_zero", 1'b1);
        idle();
    endtask

    task automatic test_pass_b();
        drive(C_PASS, 64'd4356, 64'd3196, 64'd3196);
        tick_check("pass_b", 1'b1);
        drive(C_PASS, 64'd1282, 64'd0, 64'd0);
        tick_check("pass_b_zero", 1'b1);
        idle();
    endtask

    task automatic test_wrap();
        drive(C_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000);
        tick_check("wrap_signed", 1'b1);
`ifdef ALU_FLAGS_EN
        checks += 3;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL wrap_signed overflow: got %0b want 1", overflow);
        end
        if (negative !== 1'b1) begin
            errors++;
            $display("FAIL wrap_signed negative: got %0b want 1", negative);
        end
        if (carry !== 1'b0) begin
            errors++;
            $display("FAIL wrap_signed carry: got %0b want 0", carry);
        end
`endif
        drive(C_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        tick_check("wrap_unsigned", 1'b1);
`ifdef ALU_FLAGS_EN
        checks += 2;
        if (carry !== 1'b1) begin
            errors++;
            $display("FAIL wrap_unsigned carry: got %0b want 1", carry);
        end
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_unsigned overflow: got %0b want 0", overflow);
        end
`endif
        drive(C_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE);
        tick_check("wrap_sub", 1'b1);
        idle();
    endtask

    task automatic test_back_to_back();
        drive(C_ADD, 64'd100, 64'd23, 64'd123);
        tick_check("b2b_0", 1'b1);
        drive(C_SUB, 64'd50, 64'd70, -64'sd20);
        tick_check("b2b_1", 1'b1);
        drive(C_OR, 64'hF0, 64'h0F, 64'hFF);
        tick_check("b2b_2", 1'b1);
        // Outputs must hold across idle cycles with junk on the inputs.
        for (int i = 0; i < 3; i++) begin
            idle();
            tick_check("hold_idle", 1'b0);
        end
    endtask

    task automatic test_unused_code();
        drive(4'b0101, 64'd77, 64'd99, 64'd0);
        tick_check("unused_0101", 1'b1);
        drive(C_PASS, 64'd0, 64'd42, 64'd42);
        tick_check("unused_preload", 1'b1);
        drive(4'b1111, 64'd5, 64'd6, 64'd0);
        tick_check("unused_1111", 1'b1);
        idle();
        tick_check("final_idle", 1'b0);
    endtask

    initial begin
        test_reset();
        test_logic();
        test_arith();
        test_pass_b();
        test_wrap();
        test_back_to_back();
        test_unused_code();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
